// File: rtl/memstage_pkg.sv
// Shared definitions for the memory stage: FSM encoding, destination-register
// field location and the default access timeout.
package memstage_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_e;

   localparam int RD_MSB          = 7;
   localparam int RD_LSB          = 5;
   localparam int DEFAULT_TIMEOUT = 15;
   localparam int TIMER_W         = 8;

endpackage

// File: rtl/access_timer.sv
// Counts ACCESS cycles spent waiting for the data memory and flags the edge on
// which the wait budget runs out.
module access_timer
   import memstage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TIMER_W-1:0] LAST_WAIT = TIMER_W'(TIMEOUT_CYCLES - 1);

   logic [TIMER_W-1:0] cnt_q;
   logic [TIMER_W-1:0] cnt_d;

   // The current edge is wait number cnt_q+1, so it is the last one when cnt_q == TIMEOUT-1.
   assign expired = enable && (cnt_q == LAST_WAIT);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: passes ALU ops straight to writeback in one cycle and
// runs loads/stores through a request/ack handshake with an access timeout.
module memory_stage
   import memstage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [15:0] ex_instr,
   input  logic [15:0] ex_aluresult,
   input  logic [15:0] ex_storedata,
   input  logic        ex_isld,
   input  logic        ex_isst,
   input  logic        ex_iswb,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [15:0] dmem_rdata,
   output logic        wb_valid,
   output logic        iswb,
   output logic        isld,
   output logic [15:0] instr,
   output logic [15:0] ldresult,
   output logic [15:0] aluresult,
   output logic        mem_err
);

   state_e      state_q, state_d;
   logic        dmem_req_q, dmem_req_d;
   logic        dmem_we_q, dmem_we_d;
   logic [15:0] dmem_addr_q, dmem_addr_d;
   logic [15:0] dmem_wdata_q, dmem_wdata_d;
   logic        wb_valid_q, wb_valid_d;
   logic        iswb_q, iswb_d;
   logic        isld_q, isld_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] ldresult_q, ldresult_d;
   logic [15:0] aluresult_q, aluresult_d;
   logic        mem_err_q, mem_err_d;
   logic        pend_iswb_q, pend_iswb_d;
   logic        pend_isld_q, pend_isld_d;

   logic timer_clear;
   logic timer_enable;
   logic timer_expired;

   assign timer_clear  = (state_q == ST_IDLE);
   assign timer_enable = (state_q == ST_ACCESS) && !dmem_ack;

   access_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (timer_clear),
      .enable (timer_enable),
      .expired(timer_expired)
   );

   // Writeback flags are pulses: they default low and only rise on a completion edge.
   always_comb begin
      state_d      = state_q;
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      instr_d      = instr_q;
      ldresult_d   = ldresult_q;
      aluresult_d  = aluresult_q;
      pend_iswb_d  = pend_iswb_q;
      pend_isld_d  = pend_isld_q;
      wb_valid_d   = 1'b0;
      iswb_d       = 1'b0;
      isld_d       = 1'b0;
      mem_err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ex_valid) begin
               instr_d     = ex_instr;
               aluresult_d = ex_aluresult;
               if (ex_isld || ex_isst) begin
                  state_d      = ST_ACCESS;
                  dmem_req_d   = 1'b1;
                  dmem_we_d    = ex_isst && !ex_isld;
                  dmem_addr_d  = ex_aluresult;
                  dmem_wdata_d = ex_storedata;
                  pend_iswb_d  = ex_iswb;
                  pend_isld_d  = ex_isld;
               end else begin
                  wb_valid_d = 1'b1;
                  iswb_d     = ex_iswb;
                  ldresult_d = 16'h0000;
               end
            end
         end
         ST_ACCESS: begin
            // An ack on the timeout edge still completes normally.
            if (dmem_ack) begin
               state_d    = ST_IDLE;
               dmem_req_d = 1'b0;
               wb_valid_d = 1'b1;
               if (pend_isld_q) begin
                  ldresult_d = dmem_rdata;
                  isld_d     = 1'b1;
                  iswb_d     = pend_iswb_q;
               end else begin
                  ldresult_d = 16'h0000;
               end
            end else if (timer_expired) begin
               state_d    = ST_IDLE;
               dmem_req_d = 1'b0;
               wb_valid_d = 1'b1;
               ldresult_d = 16'h0000;
               mem_err_d  = 1'b1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            dmem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= 16'h0000;
         dmem_wdata_q <= 16'h0000;
         wb_valid_q   <= 1'b0;
         iswb_q       <= 1'b0;
         isld_q       <= 1'b0;
         instr_q      <= 16'h0000;
         ldresult_q   <= 16'h0000;
         aluresult_q  <= 16'h0000;
         mem_err_q    <= 1'b0;
         pend_iswb_q  <= 1'b0;
         pend_isld_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         wb_valid_q   <= wb_valid_d;
         iswb_q       <= iswb_d;
         isld_q       <= isld_d;
         instr_q      <= instr_d;
         ldresult_q   <= ldresult_d;
         aluresult_q  <= aluresult_d;
         mem_err_q    <= mem_err_d;
         pend_iswb_q  <= pend_iswb_d;
         pend_isld_q  <= pend_isld_d;
      end
   end

   assign ex_ready   = (state_q == ST_IDLE);
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign wb_valid   = wb_valid_q;
   assign iswb       = iswb_q;
   assign isld       = isld_q;
   assign instr      = instr_q;
   assign ldresult   = ldresult_q;
   assign aluresult  = aluresult_q;
   assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed scoreboard bench for memory_stage: expected completions are queued
// as instructions are issued and a negedge monitor checks each writeback pulse.
module tb_memory_stage;
   import memstage_pkg::*;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic [15:0] ex_instr = '0;
   logic [15:0] ex_aluresult = '0;
   logic [15:0] ex_storedata = '0;
   logic        ex_isld = 1'b0;
   logic        ex_isst = 1'b0;
   logic        ex_iswb = 1'b0;
   logic        dmem_req;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [15:0] dmem_rdata = '0;
   logic        wb_valid;
   logic        iswb;
   logic        isld;
   logic [15:0] instr;
   logic [15:0] ldresult;
   logic [15:0] aluresult;
   logic        mem_err;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] aluresult;
      logic [15:0] ldresult;
      logic        iswb;
      logic        isld;
      logic        mem_err;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   logic mon_en = 1'b0;

   memory_stage #(
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .ex_instr    (ex_instr),
      .ex_aluresult(ex_aluresult),
      .ex_storedata(ex_storedata),
      .ex_isld     (ex_isld),
      .ex_isst     (ex_isst),
      .ex_iswb     (ex_iswb),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_ack    (dmem_ack),
      .dmem_rdata  (dmem_rdata),
      .wb_valid    (wb_valid),
      .iswb        (iswb),
      .isld        (isld),
      .instr       (instr),
      .ldresult    (ldresult),
      .aluresult   (aluresult),
      .mem_err     (mem_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %b want %b", name, act, req);
      end
   endtask

   task automatic pushExp(input logic [15:0] i, input logic [15:0] a, input logic [15:0] l,
                          input logic wb, input logic ld, input logic err);
      exp_t e;
      e.instr     = i;
      e.aluresult = a;
      e.ldresult  = l;
      e.iswb      = wb;
      e.isld      = ld;
      e.mem_err   = err;
      exp_q.push_back(e);
   endtask

   // Called on a negedge; returns on the negedge right after the accepting edge.
   task automatic applyStimulus(input logic [15:0] i, input logic [15:0] a, input logic [15:0] sd,
                                input logic ld, input logic st, input logic wb, output int stalls);
      stalls = 0;
      while (ex_ready !== 1'b1 && stalls < 64) begin
         @(negedge clk);
         stalls++;
      end
      checkBit("accept_ready", ex_ready, 1'b1);
      ex_valid     = 1'b1;
      ex_instr     = i;
      ex_aluresult = a;
      ex_storedata = sd;
      ex_isld      = ld;
      ex_isst      = st;
      ex_iswb      = wb;
      @(negedge clk);
      ex_valid = 1'b0;
      ex_isld  = 1'b0;
      ex_isst  = 1'b0;
      ex_iswb  = 1'b0;
   endtask

   // Monitor: every writeback pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (wb_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_completion: got instr %h want none", instr);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               checkOutput("wb_instr", instr, e.instr);
               checkOutput("wb_aluresult", aluresult, e.aluresult);
               checkOutput("wb_ldresult", ldresult, e.ldresult);
               checkBit("wb_iswb", iswb, e.iswb);
               checkBit("wb_isld", isld, e.isld);
               checkBit("wb_mem_err", mem_err, e.mem_err);
            end
         end else begin
            checkBit("idle_iswb", iswb, 1'b0);
            checkBit("idle_mem_err", mem_err, 1'b0);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int stalls;
      int ready_low;
      logic [2:0] rd;

      // Reset state
      #12;
      checkBit("rst_ex_ready", ex_ready, 1'b1);
      checkBit("rst_dmem_req", dmem_req, 1'b0);
      checkBit("rst_dmem_we", dmem_we, 1'b0);
      checkBit("rst_wb_valid", wb_valid, 1'b0);
      checkBit("rst_iswb", iswb, 1'b0);
      checkBit("rst_isld", isld, 1'b0);
      checkBit("rst_mem_err", mem_err, 1'b0);
      checkOutput("rst_dmem_addr", dmem_addr, 16'h0000);
      checkOutput("rst_dmem_wdata", dmem_wdata, 16'h0000);
      checkOutput("rst_instr", instr, 16'h0000);
      checkOutput("rst_ldresult", ldresult, 16'h0000);
      checkOutput("rst_aluresult", aluresult, 16'h0000);
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // Single ALU op, destination register 5
      pushExp(16'h00A0, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'h00A0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, stalls);
      rd = instr[RD_MSB:RD_LSB];
      checkOutput("alu_rd_field", {13'd0, rd}, 16'd5);
      checkBit("alu_no_req", dmem_req, 1'b0);

      // Back-to-back ALU ops, one per cycle
      pushExp(16'h0020, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
      pushExp(16'h0040, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
      pushExp(16'h00E0, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'h0020, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, stalls);
      checkOutput("b2b_stall0", 16'(stalls), 16'd0);
      applyStimulus(16'h0040, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, stalls);
      checkOutput("b2b_stall1", 16'(stalls), 16'd0);
      applyStimulus(16'h00E0, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, stalls);
      checkOutput("b2b_stall2", 16'(stalls), 16'd0);
      @(negedge clk);

      // Load with three wait cycles, ack on the fourth ACCESS edge
      pushExp(16'h0060, 16'h0040, 16'hBEEF, 1'b1, 1'b1, 1'b0);
      applyStimulus(16'h0060, 16'h0040, 16'h7777, 1'b1, 1'b0, 1'b1, stalls);
      ready_low = 0;
      for (int k = 0; k < 4; k++) begin
         if (!ex_ready) ready_low++;
         checkBit("ld_req_held", dmem_req, 1'b1);
         checkBit("ld_we", dmem_we, 1'b0);
         checkOutput("ld_addr", dmem_addr, 16'h0040);
         if (k == 3) begin
            dmem_ack   = 1'b1;
            dmem_rdata = 16'hBEEF;
         end
         @(negedge clk);
      end
      dmem_ack   = 1'b0;
      dmem_rdata = 16'h0000;
      if (!ex_ready) ready_low++;
      checkOutput("ld_ready_low_cycles", 16'(ready_low), 16'd4);
      checkBit("ld_req_drop", dmem_req, 1'b0);
      @(negedge clk);
      checkBit("ld_wb_single", wb_valid, 1'b0);

      // Store with writeback flag set, ack on the next edge
      pushExp(16'h0180, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'h0180, 16'h0010, 16'h5A5A, 1'b0, 1'b1, 1'b1, stalls);
      checkBit("st_req", dmem_req, 1'b1);
      checkBit("st_we", dmem_we, 1'b1);
      checkOutput("st_addr", dmem_addr, 16'h0010);
      checkOutput("st_wdata", dmem_wdata, 16'h5A5A);
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
      checkBit("st_req_drop", dmem_req, 1'b0);

      // Load and store both flagged behaves as a load
      pushExp(16'h00C0, 16'h0022, 16'h1357, 1'b1, 1'b1, 1'b0);
      applyStimulus(16'h00C0, 16'h0022, 16'h9999, 1'b1, 1'b1, 1'b1, stalls);
      checkBit("ldst_we", dmem_we, 1'b0);
      dmem_ack   = 1'b1;
      dmem_rdata = 16'h1357;
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = 16'h0000;

      // Load that never gets an ack times out after TO ACCESS edges
      pushExp(16'h0040, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'h0040, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1, stalls);
      for (int k = 0; k < TO; k++) begin
         checkBit("to_req_held", dmem_req, 1'b1);
         @(negedge clk);
      end
      checkBit("to_req_drop", dmem_req, 1'b0);
      checkBit("to_mem_err", mem_err, 1'b1);
      checkBit("to_ready", ex_ready, 1'b1);
      @(negedge clk);
      checkBit("to_err_single", mem_err, 1'b0);

      // Ack arriving on the timeout edge completes normally
      pushExp(16'h00A0, 16'h0200, 16'h2468, 1'b1, 1'b1, 1'b0);
      applyStimulus(16'h00A0, 16'h0200, 16'h0000, 1'b1, 1'b0, 1'b1, stalls);
      for (int k = 0; k < TO - 1; k++) begin
         @(negedge clk);
      end
      checkBit("race_req_held", dmem_req, 1'b1);
      dmem_ack   = 1'b1;
      dmem_rdata = 16'h2468;
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = 16'h0000;
      checkBit("race_no_err", mem_err, 1'b0);
      checkBit("race_req_drop", dmem_req, 1'b0);

      // Ack while idle is ignored
      dmem_ack   = 1'b1;
      dmem_rdata = 16'hFFFF;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checkBit("idle_ack_no_wb", wb_valid, 1'b0);
      end
      dmem_ack = 1'b0;

      // Reset in the middle of an access abandons it
      applyStimulus(16'h0060, 16'h0300, 16'h0000, 1'b1, 1'b0, 1'b1, stalls);
      checkBit("rstmid_req_before", dmem_req, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkBit("rstmid_req", dmem_req, 1'b0);
      checkBit("rstmid_ready", ex_ready, 1'b1);
      checkBit("rstmid_wb", wb_valid, 1'b0);
      checkOutput("rstmid_addr", dmem_addr, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pushExp(16'h00A0, 16'h4321, 16'h0000, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'h00A0, 16'h4321, 16'h0000, 1'b0, 1'b0, 1'b1, stalls);
      checkOutput("post_rst_stall", 16'(stalls), 16'd0);
      checkBit("post_rst_wb", wb_valid, 1'b1);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drained", 16'(exp_q.size()), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
